// File: rtl/button_sr_driver_pkg.sv
// ---------------------------------------------------------------------------
// sr_drv_pkg -- shared constants and types for the push-button SR driver.
//   DEBOUNCE_CYCLES_DEFAULT : stable cycles needed before a debounced level flips
//   CNT_W                   : width of each channel's debounce counter
//   SYNC_STAGES             : depth of the input synchronizer
//   req_kind_t / classify_req : names the four possible request combinations
// ---------------------------------------------------------------------------
package sr_drv_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int CNT_W                   = 8;
  localparam int SYNC_STAGES             = 2;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_SET  = 2'b01,
    REQ_RST  = 2'b10,
    REQ_BOTH = 2'b11
  } req_kind_t;

  // Folds the two per-channel requests into one enum so the arbiter can
  // switch on a named case instead of a raw bit pair.
  function automatic req_kind_t classify_req(input logic set_req, input logic rst_req);
    return req_kind_t'({rst_req, set_req});
  endfunction

endpackage

// File: rtl/button_sr_driver_if.sv
// ---------------------------------------------------------------------------
// button_sr_driver_if -- groups the raw buttons and the latch-side pulses.
//   btn_set, btn_rst : raw asynchronous push-buttons (driven by master)
//   S, R             : one-cycle set/reset pulses to the SR latch (driven by slave)
//   conflict         : one-cycle flag, both requests collided and were dropped
// The driver block itself uses the slave view.
// ---------------------------------------------------------------------------
interface button_sr_driver_if;

  logic btn_set;
  logic btn_rst;
  logic S;
  logic R;
  logic conflict;

  modport master (output btn_set, output btn_rst, input S, input R, input conflict);
  modport slave  (input btn_set, input btn_rst, output S, output R, output conflict);

endinterface

// File: rtl/button_sr_driver_debounce.sv
// ---------------------------------------------------------------------------
// debounce_cell -- synchronizer, debounce counter and rise detector for one
// push-button.
//   clk, rst : clock and asynchronous active-high reset
//   din      : raw button input
//   level    : debounced button level
//   rise     : one-cycle pulse in the cycle after level goes 0 -> 1
// ---------------------------------------------------------------------------
module debounce_cell
  import sr_drv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync2;
  logic                   deb;
  logic [CNT_W-1:0]       cnt;

  assign sync2 = sync_q[SYNC_STAGES-1];
  assign level = deb;

  // Shift the raw button through the synchronizer, then count how many
  // consecutive edges the synchronized value has disagreed with the
  // debounced level. Any agreement (a bounce back) restarts the count.
  // When the count completes the level flips and the counter clears in the
  // same edge, so cnt never reaches DEBOUNCE_CYCLES. rise is registered at
  // that same edge and only for a 0 -> 1 flip, giving exactly one pulse per
  // debounced press and none on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      deb    <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= 1'b0;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == LAST_COUNT) begin
        deb  <= ~deb;
        cnt  <= '0;
        rise <= ~deb;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_sr_driver.sv
// ---------------------------------------------------------------------------
// button_sr_driver -- turns two bouncing push-buttons into clean one-cycle
// set/reset pulses for a downstream SR latch, never asserting both at once.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave view of button_sr_driver_if
//              (btn_set, btn_rst in; S, R, conflict out)
// Parameter DEBOUNCE_CYCLES (1..255): stable cycles before a level changes.
// ---------------------------------------------------------------------------
module button_sr_driver
  import sr_drv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  button_sr_driver_if.slave   bus
);

  logic set_level, set_rise;
  logic rst_level, rst_rise;
  logic set_req, rst_req;
  logic s_next, r_next, conflict_next;
  logic s_q, r_q, conflict_q;

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.btn_set),
    .level (set_level),
    .rise  (set_rise)
  );

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.btn_rst),
    .level (rst_level),
    .rise  (rst_rise)
  );

  // A request is a rise that is still backed by a high debounced level; the
  // two always coincide, the qualification just keeps the request tied to
  // the level it came from.
  assign set_req = set_rise & set_level;
  assign rst_req = rst_rise & rst_level;

  // Arbitrate the two requests. A lone request passes through; simultaneous
  // requests are both dropped and flagged so the latch simply holds.
  always_comb begin
    s_next        = 1'b0;
    r_next        = 1'b0;
    conflict_next = 1'b0;
    case (classify_req(set_req, rst_req))
      REQ_SET:  s_next        = 1'b1;
      REQ_RST:  r_next        = 1'b1;
      REQ_BOTH: conflict_next = 1'b1;
      default:  ;
    endcase
  end

  // Register the arbitration result so the latch sees glitch-free pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_next;
      r_q        <= r_next;
      conflict_q <= conflict_next;
    end
  end

  assign bus.S        = s_q;
  assign bus.R        = r_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_button_sr_driver.sv
// ---------------------------------------------------------------------------
// tb_button_sr_driver -- directed self-checking bench for button_sr_driver
// with DEBOUNCE_CYCLES = 4. Inputs change 1 time unit after a rising edge;
// outputs are sampled at the same point, so "edge e" below means the output
// observed just after the e-th rising edge counted from the scenario start.
// ---------------------------------------------------------------------------
module tb_button_sr_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  button_sr_driver_if bus_if ();

  button_sr_driver #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return the design to a known idle state with both buttons released.
  task automatic do_reset();
    bus_if.btn_set = 1'b0;
    bus_if.btn_rst = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Async reset must clear outputs and internal state without a clock edge.
  task automatic test_reset();
    do_reset();
    bus_if.btn_set = 1'b1;
    for (int e = 1; e <= 7; e++) tick();
    checks++;
    if (bus_if.S !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_pre_pulse: S=%b expected 1", bus_if.S);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.S, bus_if.R, bus_if.conflict} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_async_outputs: SRC=%b expected 000",
               {bus_if.S, bus_if.R, bus_if.conflict});
    end
    checks++;
    if ({dut.u_set.deb, dut.u_set.sync_q, dut.u_set.cnt} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_async_state: deb=%b sync=%b cnt=%0d expected all 0",
               dut.u_set.deb, dut.u_set.sync_q, dut.u_set.cnt);
    end
    tick();
    checks++;
    if ({bus_if.S, bus_if.R, bus_if.conflict} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_held: SRC=%b expected 000",
               {bus_if.S, bus_if.R, bus_if.conflict});
    end
    rst = 1'b0;
    bus_if.btn_set = 1'b0;
  endtask

  // Press before edge 10 and hold: single S pulse after edge 16.
  task automatic test_clean_press();
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      bus_if.btn_set = (e >= 10);
      tick();
      checks++;
      if (bus_if.S !== (e == 16)) begin
        failures++;
        $display("[TB] FAIL clean_press_S e=%0d: S=%b expected %b", e, bus_if.S, e == 16);
      end
      checks++;
      if ({bus_if.R, bus_if.conflict} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL clean_press_RC e=%0d: RC=%b expected 00", e,
                 {bus_if.R, bus_if.conflict});
      end
      checks++;
      if (dut.u_set.cnt > 8'd3) begin
        failures++;
        $display("[TB] FAIL clean_press_cnt e=%0d: cnt=%0d expected <=3", e, dut.u_set.cnt);
      end
    end
  endtask

  // btn_rst bounces 1,0,1,0 then holds from edge 5: R pulse after edge 11.
  task automatic test_bounce();
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      bus_if.btn_rst = (e >= 5) ? 1'b1 : pat[e-1];
      tick();
      checks++;
      if (bus_if.R !== (e == 11)) begin
        failures++;
        $display("[TB] FAIL bounce_R e=%0d: R=%b expected %b", e, bus_if.R, e == 11);
      end
      checks++;
      if ({bus_if.S, bus_if.conflict} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL bounce_SC e=%0d: SC=%b expected 00", e,
                 {bus_if.S, bus_if.conflict});
      end
    end
  endtask

  // Both buttons rise together: conflict after edge 7, no S or R at all.
  task automatic test_collision();
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      bus_if.btn_set = 1'b1;
      bus_if.btn_rst = 1'b1;
      tick();
      checks++;
      if (bus_if.conflict !== (e == 7)) begin
        failures++;
        $display("[TB] FAIL collision_flag e=%0d: conflict=%b expected %b", e,
                 bus_if.conflict, e == 7);
      end
      checks++;
      if ({bus_if.S, bus_if.R} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL collision_SR e=%0d: SR=%b expected 00", e, {bus_if.S, bus_if.R});
      end
    end
  endtask

  // btn_set before edge 1, btn_rst before edge 3: S after 7, R after 9.
  task automatic test_staggered();
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      bus_if.btn_set = 1'b1;
      bus_if.btn_rst = (e >= 3);
      tick();
      checks++;
      if ({bus_if.S, bus_if.R, bus_if.conflict} !== {e == 7, e == 9, 1'b0}) begin
        failures++;
        $display("[TB] FAIL staggered e=%0d: SRC=%b expected %b", e,
                 {bus_if.S, bus_if.R, bus_if.conflict}, {e == 7, e == 9, 1'b0});
      end
    end
  endtask

  // Reset two cycles into a press with the button held: the partial count is
  // lost and a fresh S pulse comes 7 edges after reset deasserts.
  task automatic test_reset_mid_debounce();
    do_reset();
    bus_if.btn_set = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus_if.S, dut.u_set.cnt} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_held: S=%b cnt=%0d expected 0/0", bus_if.S, dut.u_set.cnt);
    end
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      checks++;
      if (bus_if.S !== (e == 7)) begin
        failures++;
        $display("[TB] FAIL mid_reset_S e=%0d: S=%b expected %b", e, bus_if.S, e == 7);
      end
    end
    bus_if.btn_set = 1'b0;
  endtask

  // Hold 50 cycles, release, press again: exactly two S pulses overall.
  task automatic test_hold_release();
    int pulses = 0;
    int stray  = 0;
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      bus_if.btn_set = 1'b1;
      tick();
      pulses += int'(bus_if.S);
      stray  += int'(bus_if.R) + int'(bus_if.conflict);
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("[TB] FAIL hold_first: pulses=%0d expected 1", pulses);
    end
    for (int e = 1; e <= 12; e++) begin
      bus_if.btn_set = 1'b0;
      tick();
      pulses += int'(bus_if.S);
      stray  += int'(bus_if.R) + int'(bus_if.conflict);
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("[TB] FAIL hold_release: pulses=%0d expected 1", pulses);
    end
    for (int e = 1; e <= 20; e++) begin
      bus_if.btn_set = 1'b1;
      tick();
      pulses += int'(bus_if.S);
      stray  += int'(bus_if.R) + int'(bus_if.conflict);
    end
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("[TB] FAIL hold_second: pulses=%0d expected 2", pulses);
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("[TB] FAIL hold_stray: R/conflict cycles=%0d expected 0", stray);
    end
    bus_if.btn_set = 1'b0;
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    bus_if.btn_set = 1'b0;
    bus_if.btn_rst = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_collision();
    test_staggered();
    test_reset_mid_debounce();
    test_hold_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_sr_driver.md
BUTTON_SR_DRIVER -- requirements
Module: button_sr_driver

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, range 1..255: consecutive stable cycles required before a debounced level changes.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 btn_set  input  1  raw, asynchronous, bouncing set push-button.
REQ-005 btn_rst  input  1  raw, asynchronous, bouncing reset push-button.
REQ-006 S  output  1  registered one-cycle set pulse to the downstream SR latch.
REQ-007 R  output  1  registered one-cycle reset pulse to the downstream SR latch.
REQ-008 conflict  output  1  registered one-cycle flag: set and reset requests collided and both were dropped.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-010 Each channel SHALL keep a debounced level deb and an 8-bit counter cnt.
REQ-011 cnt SHALL clear to 0 on any edge where sync2 equals deb.
REQ-012 cnt SHALL increment on each edge where sync2 differs from deb.
REQ-013 On the DEBOUNCE_CYCLES-th consecutive differing edge, deb SHALL toggle and cnt SHALL clear.
REQ-014 A rise of deb (0->1) SHALL raise that channel's request for exactly one cycle; a fall of deb SHALL raise no request.
REQ-015 Latency: a raw input rising before edge k and held stable SHALL give deb=1 after edge k+1+DEBOUNCE_CYCLES and S (or R) =1 after edge k+2+DEBOUNCE_CYCLES, for exactly one cycle.
REQ-016 A bounce (sync2 returning to deb) before the count completes SHALL restart the count from 0 and produce no pulse.
REQ-017 When only the set request is active, the output SHALL be S=1, R=0, conflict=0.
REQ-018 When only the reset request is active, the output SHALL be R=1, S=0, conflict=0.
REQ-019 When both requests are active in the same cycle, the output SHALL be S=0, R=0, conflict=1, so the latch holds its state.
REQ-020 S and R SHALL never be 1 in the same cycle under any input sequence.
REQ-021 A held button SHALL produce exactly one pulse per press; the next pulse requires a debounced release followed by a debounced press.
REQ-022 cnt SHALL never exceed DEBOUNCE_CYCLES-1 after any edge.

Reset
REQ-023 While rst=1, all of sync1, sync2, deb, cnt, S, R and conflict SHALL be 0, independent of clk.
REQ-024 If rst asserts mid-debounce, the partial count SHALL be discarded, no pulse shall be emitted, and debouncing SHALL restart from 0 after release.
REQ-025 If a button is held high across rst release, it SHALL be treated as a new press and give one pulse with the REQ-015 latency measured from the first edge after release.

Structure
REQ-026 DEBOUNCE_CYCLES default, the counter width (8) and the synchronizer depth (2) SHALL live in the shared package sr_drv_pkg.
REQ-027 The synchronizer, debounce counter and rise detector SHALL form one sub-module, debounce_cell (ports clk, rst, din, level, rise), instantiated once per button.
REQ-028 Collision arbitration and the output registers SHALL live in button_sr_driver.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Clean press: btn_set 0->1 before edge 10 and held -> S=1 only after edge 16, R=0, conflict=0 throughout.
REQ-030 Bounce: btn_rst toggles 1,0,1,0 on successive cycles, then holds 1 -> no R pulse during the bounce; one R pulse 6 edges after the final rise.
REQ-031 Collision: both buttons rise before the same edge -> conflict=1 for one cycle, S=R=0 every cycle.
REQ-032 Staggered presses: btn_set rises 2 cycles before btn_rst -> S pulse, then R pulse 2 cycles later, never overlapping.
REQ-033 Reset mid-debounce: btn_set rises, rst pulses 2 cycles later, btn_set stays held -> no S before release; one S pulse 7 edges after rst deasserts.
REQ-034 Hold and release: btn_set held 50 cycles, released, then pressed again -> exactly two S pulses.
